// File: rtl/lane_reorder_serializer_pkg.sv
// Shared definitions for the Rx PCS lane reorder / width converter:
// default geometry, FSM state encoding and a width helper.
package lane_reorder_serializer_pkg;

    localparam int NB_DATA_DEF = 66;
    localparam int N_LANES_DEF = 20;
    localparam int N_OUT_DEF   = 4;

    typedef enum logic [1:0] {
        ST_NOMAP = 2'd0,
        ST_EMPTY = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    // A beat counter still needs one bit when a frame is a single beat.
    function automatic int beat_width(input int n_beats);
        return (n_beats > 1) ? $clog2(n_beats) : 1;
    endfunction

endpackage

// File: rtl/lane_reorder_serializer_map_checker.sv
// Combinational check that a lane-id vector is a permutation of 0..N_LANES-1:
// every id in range and the OR of all decoded one-hots is all ones.
module lane_reorder_serializer_map_checker
    import lane_reorder_serializer_pkg::*;
#(
    parameter int N_LANES = N_LANES_DEF,
    parameter int NB_ID   = $clog2(N_LANES)
) (
    input  logic [NB_ID*N_LANES-1:0] lane_ids,
    output logic                     ok
);

    logic [N_LANES-1:0] seen;
    logic               in_range;
    logic [NB_ID-1:0]   id;

    always_comb begin
        seen     = '0;
        in_range = 1'b1;
        id       = '0;
        for (int k = 0; k < N_LANES; k++) begin
            id = lane_ids[(N_LANES-1-k)*NB_ID +: NB_ID];
            if (int'(id) >= N_LANES) begin
                in_range = 1'b0;
            end else begin
                seen[id] = 1'b1;
            end
        end
        ok = in_range && (&seen);
    end

endmodule

// File: rtl/lane_reorder_serializer.sv
// Rx PCS lane reorder plus N_LANES:N_OUT width converter. A deskewed frame is
// reordered into logical lanes through a validated map and drained as N_BEATS beats.
module lane_reorder_serializer
    import lane_reorder_serializer_pkg::*;
#(
    parameter int NB_DATA = NB_DATA_DEF,
    parameter int N_LANES = N_LANES_DEF,
    parameter int N_OUT   = N_OUT_DEF
) (
    input  logic                         i_clock,
    input  logic                         i_reset,
    input  logic                         i_enable,
    input  logic                         i_valid,
    output logic                         o_ready,
    input  logic [NB_DATA*N_LANES-1:0]   i_data,
    input  logic                         i_map_load,
    input  logic [$clog2(N_LANES)*N_LANES-1:0] i_lane_ids,
    output logic                         o_map_valid,
    output logic                         o_map_err,
    input  logic                         i_ready,
    output logic                         o_valid,
    output logic [NB_DATA*N_OUT-1:0]     o_data,
    output logic                         o_sof,
    output logic                         o_eof,
    output state_t                       dbg_state
);

    localparam int NB_ID   = $clog2(N_LANES);
    localparam int N_BEATS = N_LANES / N_OUT;
    localparam int NB_BEAT = beat_width(N_BEATS);
    localparam logic [NB_BEAT-1:0] LAST_BEAT = NB_BEAT'(N_BEATS - 1);

    if (N_LANES % N_OUT != 0) begin : g_bad_cfg
        $error("lane_reorder_serializer: N_LANES must be a multiple of N_OUT");
    end

    state_t             state_q;
    logic [NB_BEAT-1:0] beat_q;
    logic [NB_DATA-1:0] frame_q [N_LANES];
    logic [NB_ID-1:0]   map_q   [N_LANES];
    logic               map_valid_q;
    logic               map_err_q;

    logic [NB_DATA-1:0] phy [N_LANES];
    logic [NB_ID-1:0]   ids [N_LANES];
    logic               map_ok;
    logic               last_beat;
    logic               capture;
    logic [NB_ID-1:0]   base;

    for (genvar k = 0; k < N_LANES; k++) begin : g_unpack
        assign phy[k] = i_data[(N_LANES-1-k)*NB_DATA +: NB_DATA];
        assign ids[k] = i_lane_ids[(N_LANES-1-k)*NB_ID +: NB_ID];
    end

    lane_reorder_serializer_map_checker #(
        .N_LANES (N_LANES),
        .NB_ID   (NB_ID)
    ) u_map_checker (
        .lane_ids (i_lane_ids),
        .ok       (map_ok)
    );

    // Handshake: a frame is taken when i_valid & o_ready & i_enable; a beat is
    // consumed when o_valid & i_ready. Both sides freeze while i_enable is low.
    assign last_beat = (beat_q == LAST_BEAT);
    assign o_ready   = i_enable && ((state_q == ST_EMPTY) ||
                                    ((state_q == ST_DRAIN) && last_beat && i_ready));
    assign capture   = o_ready && i_valid;
    assign o_valid   = i_enable && (state_q == ST_DRAIN);
    assign o_sof     = o_valid && (beat_q == '0);
    assign o_eof     = o_valid && last_beat;

    assign o_map_valid = map_valid_q;
    assign o_map_err   = map_err_q;
    assign dbg_state   = state_q;

    assign base = NB_ID'(beat_q) * NB_ID'(N_OUT);

    for (genvar j = 0; j < N_OUT; j++) begin : g_out
        assign o_data[(N_OUT-1-j)*NB_DATA +: NB_DATA] = frame_q[base + NB_ID'(j)];
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q     <= ST_NOMAP;
            beat_q      <= '0;
            map_valid_q <= 1'b0;
            map_err_q   <= 1'b0;
            for (int k = 0; k < N_LANES; k++) begin
                frame_q[k] <= '0;
                map_q[k]   <= NB_ID'(k);
            end
        end else begin
            // Map updates ignore i_enable; a capture in the same cycle still
            // sees the old map because map_q is read before it is written.
            if (i_map_load) begin
                if (map_ok) begin
                    map_q       <= ids;
                    map_valid_q <= 1'b1;
                    map_err_q   <= 1'b0;
                end else begin
                    map_err_q   <= 1'b1;
                end
            end

            if (capture) begin
                for (int k = 0; k < N_LANES; k++) begin
                    frame_q[k] <= phy[map_q[k]];
                end
            end

            if (i_enable) begin
                case (state_q)
                    ST_NOMAP: begin
                        if (map_valid_q) state_q <= ST_EMPTY;
                    end
                    ST_EMPTY: begin
                        if (i_valid) begin
                            state_q <= ST_DRAIN;
                            beat_q  <= '0;
                        end
                    end
                    ST_DRAIN: begin
                        if (i_ready) begin
                            if (!last_beat) begin
                                beat_q <= beat_q + 1'b1;
                            end else if (i_valid) begin
                                beat_q <= '0;
                            end else begin
                                state_q <= ST_EMPTY;
                            end
                        end
                    end
                    default: state_q <= ST_NOMAP;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_lane_reorder_serializer.sv
// Self-checking bench for lane_reorder_serializer: directed scenarios plus random
// traffic, compared against a frame/beat queue model of the lane reorder.
`timescale 1ns/1ps
module tb_lane_reorder_serializer;
    import lane_reorder_serializer_pkg::*;

    localparam int NB_DATA = 66;
    localparam int N_LANES = 20;
    localparam int N_OUT   = 4;
    localparam int NB_ID   = $clog2(N_LANES);
    localparam int N_BEATS = N_LANES / N_OUT;
    localparam int BW      = NB_DATA * N_OUT;
    localparam int W       = BW + 2;
    localparam int VW      = W + 4;

    // ---------------- clock / reset / DUT ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                       rst, en, in_valid, in_ready, map_load;
    logic [NB_DATA*N_LANES-1:0] data;
    logic [NB_ID*N_LANES-1:0]   ids;
    logic                       rdy, map_valid, map_err, out_valid, sof, eof;
    logic [BW-1:0]              out_data;
    state_t                     dbg_state;

    lane_reorder_serializer #(
        .NB_DATA (NB_DATA),
        .N_LANES (N_LANES),
        .N_OUT   (N_OUT)
    ) dut (
        .i_clock     (clk),
        .i_reset     (rst),
        .i_enable    (en),
        .i_valid     (in_valid),
        .o_ready     (rdy),
        .i_data      (data),
        .i_map_load  (map_load),
        .i_lane_ids  (ids),
        .o_map_valid (map_valid),
        .o_map_err   (map_err),
        .i_ready     (in_ready),
        .o_valid     (out_valid),
        .o_data      (out_data),
        .o_sof       (sof),
        .o_eof       (eof),
        .dbg_state   (dbg_state)
    );

    // ---------------- reference model ----------------
    int n_cmp = 0;
    int n_bad = 0;
    logic [W-1:0]       exp_q[$];
    int                 m_map[N_LANES];
    bit                 m_map_valid, m_map_err, m_armed;
    logic [NB_DATA-1:0] phy_blk[N_LANES];
    int                 id_arr[N_LANES];

    function automatic bit ids_are_perm();
        int cnt[N_LANES];
        foreach (cnt[i]) cnt[i] = 0;
        foreach (id_arr[i]) begin
            if (id_arr[i] < 0 || id_arr[i] >= N_LANES) return 1'b0;
            cnt[id_arr[i]]++;
        end
        foreach (cnt[i]) if (cnt[i] != 1) return 1'b0;
        return 1'b1;
    endfunction

    function automatic bit exp_ready();
        return en && m_armed && (exp_q.size() == 0 || (exp_q.size() == 1 && in_ready));
    endfunction

    function automatic logic [VW-1:0] exp_vec();
        logic         ev;
        logic [W-1:0] f;
        ev = en && (exp_q.size() > 0);
        f  = ev ? exp_q[0] : '0;
        return {m_map_valid, m_map_err, ev, exp_ready(), f};
    endfunction

    function automatic logic [VW-1:0] got_vec();
        return {map_valid, map_err, out_valid, rdy, sof, eof, (out_valid ? out_data : BW'(0))};
    endfunction

    task automatic model_edge();
        logic [W-1:0] b;
        bit cap, pop, arm;
        if (rst) begin
            exp_q.delete();
            foreach (m_map[k]) m_map[k] = k;
            m_map_valid = 1'b0;
            m_map_err   = 1'b0;
            m_armed     = 1'b0;
            return;
        end
        pop = en && (exp_q.size() > 0) && in_ready;
        cap = en && in_valid && exp_ready();
        arm = en && m_map_valid;
        if (pop) void'(exp_q.pop_front());
        if (cap) begin
            for (int bt = 0; bt < N_BEATS; bt++) begin
                b = '0;
                for (int j = 0; j < N_OUT; j++)
                    b[BW-1:0] = (b[BW-1:0] << NB_DATA) | BW'(phy_blk[m_map[bt*N_OUT+j]]);
                b[W-1] = (bt == 0);
                b[W-2] = (bt == N_BEATS - 1);
                exp_q.push_back(b);
            end
        end
        if (arm) m_armed = 1'b1;
        if (map_load) begin
            if (ids_are_perm()) begin
                m_map       = id_arr;
                m_map_valid = 1'b1;
                m_map_err   = 1'b0;
            end else begin
                m_map_err = 1'b1;
            end
        end
    endtask

    // ---------------- drivers ----------------
    task automatic pack_inputs();
        for (int k = 0; k < N_LANES; k++) begin
            data[(N_LANES-1-k)*NB_DATA +: NB_DATA] = phy_blk[k];
            ids[(N_LANES-1-k)*NB_ID +: NB_ID]      = NB_ID'(id_arr[k]);
        end
    endtask

    task automatic tick();
        pack_inputs();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_map();
        map_load = 1'b1;
        tick();
        map_load = 1'b0;
    endtask

    task automatic shuffle_ids();
        int j, t;
        foreach (id_arr[k]) id_arr[k] = k;
        for (int k = N_LANES - 1; k > 0; k--) begin
            j = $urandom_range(0, k);
            t = id_arr[k]; id_arr[k] = id_arr[j]; id_arr[j] = t;
        end
    endtask

    task automatic random_frame();
        foreach (phy_blk[k]) phy_blk[k] = NB_DATA'({$urandom(), $urandom(), $urandom()});
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        if (got_vec() !== exp_vec() || out_data !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs got=%h data=%h exp=%h", got_vec(), out_data, exp_vec());
        end
        n_cmp++;
        if (dbg_state !== ST_NOMAP) begin
            n_bad++;
            $display("FAIL reset_state got=%0d exp=%0d", dbg_state, ST_NOMAP);
        end
        n_cmp++;
        rst = 1'b0;
    endtask

    task automatic test_identity();
        logic [BW-1:0] want;
        foreach (id_arr[k]) id_arr[k] = k;
        drive_map();
        tick();
        foreach (phy_blk[k]) phy_blk[k] = NB_DATA'(k);
        in_valid = 1'b1;
        in_ready = 1'b1;
        #1;
        if (rdy !== 1'b1 || out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL ident_ready got=%b%b exp=10", rdy, out_valid);
        end
        n_cmp++;
        tick();
        in_valid = 1'b0;
        for (int b = 0; b < N_BEATS; b++) begin
            want = '0;
            for (int j = 0; j < N_OUT; j++) want = (want << NB_DATA) | BW'(b*N_OUT + j);
            #1;
            if ({out_valid, sof, eof, out_data} !== {1'b1, b == 0, b == N_BEATS - 1, want}) begin
                n_bad++;
                $display("FAIL ident_beat%0d got=%b%b%b %h exp=%h", b, out_valid, sof, eof, out_data, want);
            end
            n_cmp++;
            if (got_vec() !== exp_vec()) begin
                n_bad++;
                $display("FAIL ident_model b=%0d got=%h exp=%h", b, got_vec(), exp_vec());
            end
            n_cmp++;
            tick();
        end
        if (out_valid !== 1'b0 || rdy !== 1'b1) begin
            n_bad++;
            $display("FAIL ident_idle got=%b%b exp=01", out_valid, rdy);
        end
        n_cmp++;
    endtask

    task automatic test_reverse();
        logic [BW-1:0] want;
        foreach (id_arr[k]) id_arr[k] = N_LANES - 1 - k;
        drive_map();
        tick();
        foreach (phy_blk[k]) phy_blk[k] = NB_DATA'(k);
        in_valid = 1'b1;
        in_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int b = 0; b < N_BEATS; b++) begin
            want = '0;
            for (int j = 0; j < N_OUT; j++) want = (want << NB_DATA) | BW'(N_LANES - 1 - (b*N_OUT + j));
            #1;
            if ((b == 0 || b == N_BEATS - 1) && (out_data !== want || out_valid !== 1'b1)) begin
                n_bad++;
                $display("FAIL rev_beat%0d got=%h exp=%h", b, out_data, want);
            end
            if (b == 0 || b == N_BEATS - 1) n_cmp++;
            if (got_vec() !== exp_vec()) begin
                n_bad++;
                $display("FAIL rev_model b=%0d got=%h exp=%h", b, got_vec(), exp_vec());
            end
            n_cmp++;
            tick();
        end
    endtask

    task automatic test_bad_map();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        foreach (id_arr[k]) id_arr[k] = k;
        id_arr[7] = 5;
        drive_map();
        in_valid = 1'b1;
        foreach (phy_blk[k]) phy_blk[k] = NB_DATA'(k + 100);
        for (int c = 0; c < 4; c++) begin
            #1;
            if ({map_err, map_valid, rdy, out_valid} !== 4'b1000) begin
                n_bad++;
                $display("FAIL badmap_hold c=%0d got=%b exp=1000", c, {map_err, map_valid, rdy, out_valid});
            end
            n_cmp++;
            if (got_vec() !== exp_vec()) begin
                n_bad++;
                $display("FAIL badmap_model c=%0d got=%h exp=%h", c, got_vec(), exp_vec());
            end
            n_cmp++;
            tick();
        end
        in_valid = 1'b0;
        foreach (id_arr[k]) id_arr[k] = k;
        drive_map();
        if ({map_err, map_valid} !== 2'b01) begin
            n_bad++;
            $display("FAIL badmap_clear got=%b exp=01", {map_err, map_valid});
        end
        n_cmp++;
        tick();
        if (rdy !== 1'b1) begin
            n_bad++;
            $display("FAIL badmap_ready got=%b exp=1", rdy);
        end
        n_cmp++;
    endtask

    task automatic test_back_to_back();
        int frames, beats, pulses;
        shuffle_ids();
        drive_map();
        tick();
        in_ready = 1'b1;
        in_valid = 1'b1;
        frames   = 0;
        beats    = 0;
        pulses   = 0;
        random_frame();
        #1;
        if (en && in_valid && exp_ready()) frames++;
        tick();
        for (int c = 0; c < N_BEATS * 10; c++) begin
            random_frame();
            in_valid = (frames < 10);
            #1;
            if (got_vec() !== exp_vec()) begin
                n_bad++;
                $display("FAIL b2b_model c=%0d got=%h exp=%h", c, got_vec(), exp_vec());
            end
            n_cmp++;
            if (out_valid !== 1'b1 || rdy !== eof) begin
                n_bad++;
                $display("FAIL b2b_stream c=%0d valid=%b ready=%b eof=%b exp valid=1 ready=eof", c, out_valid, rdy, eof);
            end
            n_cmp++;
            if (out_valid === 1'b1) beats++;
            if (rdy === 1'b1) pulses++;
            if (en && in_valid && exp_ready()) frames++;
            tick();
        end
        in_valid = 1'b0;
        #1;
        if (beats != 50 || pulses != 10 || out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL b2b_counts beats=%0d pulses=%0d valid=%b exp 50 10 0", beats, pulses, out_valid);
        end
        n_cmp++;
    endtask

    task automatic test_stall();
        int frames, beats, cyc;
        bit refresh;
        in_ready = 1'b0;
        frames   = 0;
        beats    = 0;
        cyc      = 0;
        refresh  = 1'b0;
        random_frame();
        while (cyc < 60 && beats < 2 * N_BEATS) begin
            if (refresh) random_frame();
            refresh  = 1'b0;
            en       = !(cyc >= 4 && cyc < 7);
            in_ready = (cyc % 2 == 0);
            in_valid = (frames < 2);
            #1;
            if (got_vec() !== exp_vec()) begin
                n_bad++;
                $display("FAIL stall_model c=%0d got=%h exp=%h", cyc, got_vec(), exp_vec());
            end
            n_cmp++;
            if (!en && (out_valid !== 1'b0 || rdy !== 1'b0)) begin
                n_bad++;
                $display("FAIL stall_freeze c=%0d valid=%b ready=%b exp 0 0", cyc, out_valid, rdy);
            end
            if (!en) n_cmp++;
            if (en && in_valid && exp_ready()) begin
                frames++;
                refresh = 1'b1;
            end
            if (en && out_valid === 1'b1 && in_ready) beats++;
            tick();
            cyc++;
        end
        en       = 1'b1;
        in_valid = 1'b0;
        in_ready = 1'b1;
        if (beats != 2 * N_BEATS || exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL stall_beats got=%0d left=%0d exp=%0d 0", beats, exp_q.size(), 2 * N_BEATS);
        end
        n_cmp++;
    endtask

    task automatic test_reset_mid();
        in_ready = 1'b1;
        in_valid = 1'b1;
        random_frame();
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        #1;
        if (out_valid !== 1'b1 || sof !== 1'b0 || got_vec() !== exp_vec()) begin
            n_bad++;
            $display("FAIL rstmid_beat2 got=%h exp=%h", got_vec(), exp_vec());
        end
        n_cmp++;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        if ({map_valid, map_err, out_valid, rdy, sof, eof} !== 6'b0 || out_data !== '0 || dbg_state !== ST_NOMAP) begin
            n_bad++;
            $display("FAIL rstmid_zero got=%b data=%h state=%0d exp=0 0 %0d",
                     {map_valid, map_err, out_valid, rdy, sof, eof}, out_data, dbg_state, ST_NOMAP);
        end
        n_cmp++;
        shuffle_ids();
        drive_map();
        tick();
        random_frame();
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        #1;
        if (out_valid !== 1'b1 || sof !== 1'b1 || got_vec() !== exp_vec()) begin
            n_bad++;
            $display("FAIL rstmid_restart got=%h exp=%h", got_vec(), exp_vec());
        end
        n_cmp++;
        for (int c = 0; c < N_BEATS; c++) tick();
    endtask

    task automatic test_random_traffic();
        int a;
        for (int c = 0; c < 400; c++) begin
            en       = ($urandom_range(0, 7) != 0);
            in_valid = $urandom_range(0, 1);
            in_ready = ($urandom_range(0, 3) != 0);
            map_load = ($urandom_range(0, 39) == 0);
            random_frame();
            if (map_load) begin
                shuffle_ids();
                if ($urandom_range(0, 1) == 1) begin
                    a = $urandom_range(0, N_LANES - 1);
                    if ($urandom_range(0, 1) == 1) id_arr[a] = id_arr[(a + 1) % N_LANES];
                    else id_arr[a] = $urandom_range(N_LANES, (1 << NB_ID) - 1);
                end
            end
            #1;
            if (got_vec() !== exp_vec()) begin
                n_bad++;
                $display("FAIL rand_model c=%0d got=%h exp=%h", c, got_vec(), exp_vec());
            end
            n_cmp++;
            tick();
        end
        map_load = 1'b0;
        en       = 1'b1;
        in_valid = 1'b0;
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        rst = 1'b1; en = 1'b1; in_valid = 1'b0; in_ready = 1'b0; map_load = 1'b0;
        foreach (id_arr[k]) id_arr[k] = k;
        foreach (phy_blk[k]) phy_blk[k] = '0;
        pack_inputs();
        test_reset();
        test_identity();
        test_reverse();
        test_bad_map();
        test_back_to_back();
        test_stall();
        test_reset_mid();
        test_random_traffic();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached compared=%0d", n_cmp);
        $fatal(1, "watchdog");
    end

endmodule
